// File: rtl/pll_phase_ctlr_if.sv
// Request/status bundle between a host and the PLL phase sequencer.
interface pll_phase_ctlr_if #(
  parameter int STEP_W = 8
);
  logic              req;
  logic [1:0]        req_sel;
  logic              req_dir;
  logic [STEP_W-1:0] req_steps;
  logic              busy;
  logic              ack;
  logic              err;
  logic              ready;
  logic [STEP_W-1:0] steps_done;

  modport master (
    output req, req_sel, req_dir, req_steps,
    input  busy, ack, err, ready, steps_done
  );

  modport slave (
    input  req, req_sel, req_dir, req_steps,
    output busy, ack, err, ready, steps_done
  );
endinterface

// File: rtl/pll_phase_ctlr.sv
// EHXPLLL reset/lock supervisor and dynamic phase-shift sequencer.
// Runs in the PLL reference clock domain; LOCK is asynchronous and is
// synchronised and debounced before it steers the state machine.
module pll_phase_ctlr #(
  parameter int STEP_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_FILT = 16,
  parameter int RST_CYC   = 16,
  parameter int LOCK_TMO  = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  pll_phase_ctlr_if.slave  rq,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic [1:0]       pll_phasesel,
  output logic             pll_phasedir,
  output logic             pll_phasestep,
  output logic             pll_phaseloadreg
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared phase counter covers every timed state, so size it for the longest.
  localparam int CNT_MAX = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(GAP_CYC, RST_CYC)), LOCK_TMO);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(LOCK_FILT + 1);

  typedef enum logic [2:0] {
    S_RST, S_WLOCK, S_IDLE, S_SETUP, S_PULSE, S_GAP, S_LOAD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_last;
  logic              at_last;
  logic [1:0]        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        sync_q, sync_d;
  logic [FLT_W-1:0]  flt_q, flt_d;
  logic              lock_ok;
  logic              lock_lost;

  // LOCK synchroniser and consecutive-high filter; any low sample clears it.
  always_comb begin
    sync_d = {sync_q[0], pll_lock};
    flt_d  = flt_q;
    if (!sync_q[1])
      flt_d = '0;
    else if (flt_q != FLT_W'(LOCK_FILT))
      flt_d = flt_q + FLT_W'(1);
  end

  // Gating with the current sample makes lock_ok drop on the first low sample.
  assign lock_ok   = sync_q[1] && (flt_q == FLT_W'(LOCK_FILT));
  assign lock_lost = !lock_ok && (state_q inside {S_IDLE, S_SETUP, S_PULSE, S_GAP, S_LOAD, S_DONE});

  // Terminal count for the state currently being timed.
  always_comb begin
    cnt_last = '0;
    case (state_q)
      S_RST:   cnt_last = CNT_W'(RST_CYC - 1);
      S_WLOCK: cnt_last = CNT_W'(LOCK_TMO - 1);
      S_SETUP: cnt_last = CNT_W'(SETUP_CYC - 1);
      S_PULSE: cnt_last = CNT_W'(PULSE_CYC - 1);
      S_GAP:   cnt_last = CNT_W'(GAP_CYC - 1);
      S_LOAD:  cnt_last = CNT_W'(PULSE_CYC - 1);
      default: cnt_last = '0;
    endcase
  end

  assign at_last = (cnt_q == cnt_last);

  // Next-state logic; a lock loss outside bring-up overrides whatever the state wanted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    steps_d = steps_q;
    done_d  = done_q;
    err_d   = 1'b0;

    case (state_q)
      S_RST: begin
        if (at_last) begin
          state_d = S_WLOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WLOCK: begin
        if (lock_ok) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = S_RST;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (rq.req) begin
          sel_d   = rq.req_sel;
          dir_d   = rq.req_dir;
          steps_d = rq.req_steps;
          done_d  = '0;
          cnt_d   = '0;
          state_d = (rq.req_steps != '0) ? S_SETUP : S_DONE;
        end
      end
      S_SETUP: begin
        if (at_last) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (at_last) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (at_last) begin
          // Compare against the incremented count so the full-scale request stops
          // at 2^STEP_W-1 without wrapping.
          done_d  = done_q + STEP_W'(1);
          state_d = (done_d == steps_q) ? S_LOAD : S_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (at_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase

    if (lock_lost) begin
      state_d = S_RST;
      cnt_d   = '0;
      err_d   = 1'b1;
      sel_d   = sel_q;
      dir_d   = dir_q;
      steps_d = steps_q;
      done_d  = done_q;
    end
  end

  // State, counters, latched request and lock filter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b1;
      steps_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      sync_q  <= '0;
      flt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sync_q  <= sync_d;
      flt_q   <= flt_d;
    end
  end

  // Outputs decode straight from state so async reset reaches the pins immediately.
  always_comb begin
    pll_rst          = (state_q == S_RST);
    pll_phasestep    = (state_q != S_PULSE);
    pll_phaseloadreg = (state_q != S_LOAD);
    pll_phasesel     = sel_q;
    pll_phasedir     = dir_q;
    rq.busy          = (state_q != S_IDLE);
    rq.ready         = (state_q == S_IDLE);
    rq.ack           = (state_q == S_DONE) && lock_ok;
    rq.err           = err_q;
    rq.steps_done    = done_q;
  end

endmodule
